// File: rtl/ft_dev_pkg.sv
// ft_dev_pkg: shared types and constants for the FT245 synchronous device model.
//   rx_state_e  - RX flag FSM states (data available / post-packet gap)
//   tx_state_e  - TX flag FSM states (packet open / post-packet gap)
//   rx_entry_t  - one RX buffer entry: packet-last marker plus data byte
//   ERR_*       - one-hot protocol violation codes used by the optional checker
package ft_dev_pkg;

  typedef enum logic {
    S_RX_AVAIL,
    S_RX_GAP
  } rx_state_e;

  typedef enum logic {
    S_TX_OPEN,
    S_TX_GAP
  } tx_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  localparam int ERR_W = 4;
  localparam logic [ERR_W-1:0] ERR_RD_NO_DATA     = 4'b0001;  // read while rde_n high
  localparam logic [ERR_W-1:0] ERR_RD_NO_OE       = 4'b0010;  // read while bus not enabled
  localparam logic [ERR_W-1:0] ERR_WR_NO_SPACE    = 4'b0100;  // write while txe_n high
  localparam logic [ERR_W-1:0] ERR_BUS_CONTENTION = 4'b1000;  // write while device drives bus

endpackage

// File: rtl/ft_dev_sync_fifo.sv
// ft_dev_sync_fifo: single-clock first-word-fall-through buffer with occupancy.
//   ftdi_clk, rst  - clock, synchronous active-high reset (flushes the buffer)
//   push, wr_data  - write request and data; ignored when full
//   pop            - read request; ignored when empty
//   rd_data        - head entry, valid whenever empty is low
//   empty, full    - occupancy flags decoded from the registered level
//   level          - number of stored entries (0 .. 2**DEPTH_LOG2)
module ft_dev_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  ftdi_clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (level == '0);
  assign full    = level[DEPTH_LOG2];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and level are cleared,
  // and an entry is never read before it has been written.
  always_ff @(posedge ftdi_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ft245_sync_device_model.sv
// ft245_sync_device_model: device-side model of an FT245-style synchronous FIFO
// chip. Bytes from the stream source are buffered and presented to the host via
// rde_n/ftdi_data; host writes are buffered and drained to the stream sink.
// Packet gaps, USB packet closing, siwu flushes and suspend are emulated.
//   Source side : src_data/src_last/src_valid -> src_ready
//   Sink side   : snk_data/snk_valid <- snk_ready
//   FTDI pins   : ftdi_data (inout), ftdi_rde_n, ftdi_txe_n, ftdi_rd_n, ftdi_oe_n,
//                 ftdi_wr_n, ftdi_siwu, ftdi_suspend_n (with suspend_req)
//   Status      : rx_level, tx_level, siwu_count, proto_err, err_count
// Build option: define FT_DEV_PROTO_CHECK_EN to compile in the protocol checker;
// without it proto_err and err_count are tied to zero.
module ft245_sync_device_model
  import ft_dev_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int RX_GAP     = 2,
  parameter int TX_PKT     = 512,
  parameter int TX_GAP     = 4
) (
  input  logic                  ftdi_clk,
  input  logic                  rst,
  input  logic [7:0]            src_data,
  input  logic                  src_last,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [7:0]            snk_data,
  output logic                  snk_valid,
  input  logic                  snk_ready,
  inout  wire  [7:0]            ftdi_data,
  output logic                  ftdi_rde_n,
  output logic                  ftdi_txe_n,
  input  logic                  ftdi_rd_n,
  input  logic                  ftdi_oe_n,
  input  logic                  ftdi_wr_n,
  input  logic                  ftdi_siwu,
  input  logic                  suspend_req,
  output logic                  ftdi_suspend_n,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [7:0]            siwu_count,
  output logic                  proto_err,
  output logic [7:0]            err_count
);

  localparam int GAP_W = 16;
  localparam int PKT_W = $clog2(TX_PKT + 1);

  rx_entry_t        rx_in;
  rx_entry_t        rx_head;
  logic             rx_empty, rx_full, tx_empty, tx_full;
  logic             rx_pop, tx_push, siwu_fall;
  logic             ready, suspended, siwu_q;
  rx_state_e        rx_state;
  tx_state_e        tx_state;
  logic [GAP_W-1:0] rx_gap_cnt, tx_gap_cnt;
  logic [PKT_W-1:0] pkt_cnt;

  assign rx_in     = '{last: src_last, data: src_data};
  assign src_ready = !rx_full;
  assign snk_valid = !tx_empty;
  assign suspended = !ftdi_suspend_n;

  ft_dev_sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .ftdi_clk (ftdi_clk),
    .rst      (rst),
    .push     (src_valid),
    .wr_data  (rx_in),
    .pop      (rx_pop),
    .rd_data  (rx_head),
    .empty    (rx_empty),
    .full     (rx_full),
    .level    (rx_level)
  );

  ft_dev_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .ftdi_clk (ftdi_clk),
    .rst      (rst),
    .push     (tx_push),
    .wr_data  (ftdi_data),
    .pop      (snk_ready),
    .rd_data  (snk_data),
    .empty    (tx_empty),
    .full     (tx_full),
    .level    (tx_level)
  );

  // Flags decode registered state only; 'ready' keeps both high through reset.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ftdi_rde_n = 1'b1;
    ftdi_txe_n = 1'b1;
    if (ready && !suspended) begin
      ftdi_rde_n = (rx_state == S_RX_GAP) || rx_empty;
      ftdi_txe_n = (tx_state == S_TX_GAP) || tx_full;
    end
  end

  assign rx_pop    = !ftdi_rd_n && !ftdi_oe_n && !ftdi_rde_n;
  assign tx_push   = !ftdi_wr_n && !ftdi_txe_n;
  assign siwu_fall = siwu_q && !ftdi_siwu;

  assign ftdi_data = ftdi_oe_n ? 8'hzz : (rx_empty ? 8'h00 : rx_head.data);

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      ready          <= 1'b0;
      ftdi_suspend_n <= 1'b1;
      siwu_q         <= 1'b1;
    end else begin
      ready          <= 1'b1;
      ftdi_suspend_n <= ~suspend_req;
      siwu_q         <= ftdi_siwu;
    end
  end

  // RX gap: counter loaded with RX_GAP-1 so rde_n stays high exactly RX_GAP cycles.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      rx_state   <= S_RX_AVAIL;
      rx_gap_cnt <= '0;
    end else if (!suspended) begin
      case (rx_state)
        S_RX_AVAIL: if (rx_pop && rx_head.last) begin
          rx_state   <= S_RX_GAP;
          rx_gap_cnt <= GAP_W'(RX_GAP - 1);
        end
        S_RX_GAP: begin
          if (rx_gap_cnt == '0) rx_state <= S_RX_AVAIL;
          else                  rx_gap_cnt <= rx_gap_cnt - GAP_W'(1);
        end
      endcase
    end
  end

  // TX packet emulation. A siwu flush overrides a same-cycle push's packet
  // accounting; the pushed byte itself is still stored by the TX buffer.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      tx_state   <= S_TX_OPEN;
      tx_gap_cnt <= '0;
      pkt_cnt    <= '0;
      siwu_count <= '0;
    end else if (!suspended) begin
      case (tx_state)
        S_TX_OPEN: begin
          if (siwu_fall) begin
            tx_state   <= S_TX_GAP;
            tx_gap_cnt <= GAP_W'(TX_GAP - 1);
            pkt_cnt    <= '0;
            siwu_count <= siwu_count + 8'd1;
          end else if (tx_push) begin
            if (pkt_cnt == PKT_W'(TX_PKT - 1)) begin
              tx_state   <= S_TX_GAP;
              tx_gap_cnt <= GAP_W'(TX_GAP - 1);
              pkt_cnt    <= '0;
            end else begin
              pkt_cnt <= pkt_cnt + PKT_W'(1);
            end
          end
        end
        S_TX_GAP: begin
          if (tx_gap_cnt == '0) tx_state <= S_TX_OPEN;
          else                  tx_gap_cnt <= tx_gap_cnt - GAP_W'(1);
        end
      endcase
    end
  end

`ifdef FT_DEV_PROTO_CHECK_EN
  logic [ERR_W-1:0] err_vec;

  always_comb begin
    err_vec = '0;
    if (!ftdi_rd_n && ftdi_rde_n) err_vec = err_vec | ERR_RD_NO_DATA;
    if (!ftdi_rd_n && ftdi_oe_n)  err_vec = err_vec | ERR_RD_NO_OE;
    if (!ftdi_wr_n && ftdi_txe_n) err_vec = err_vec | ERR_WR_NO_SPACE;
    if (!ftdi_wr_n && !ftdi_oe_n) err_vec = err_vec | ERR_BUS_CONTENTION;
  end

  // Several violations in one cycle count as a single event.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      proto_err <= 1'b0;
      err_count <= '0;
    end else if (|err_vec) begin
      proto_err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  assign proto_err = 1'b0;
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/ft245_sync_device_model.md
# ft245_sync_device_model

Synthesizable device-side model of the FT245-style synchronous FIFO chip, driven by `ftdi_clk`. It is the counterpart of the FPGA host interface. It presents `rde_n`/`txe_n` and drives `ftdi_data` toward the host, and honours the host's `rd_n`/`oe_n`/`wr_n`/`siwu`. It sits between a stream source/sink (bench or loopback bridge) and the host interface's FTDI pins, so the host can be exercised with packet gaps, back-pressure and flushes in simulation or on a two-FPGA board.

## Interface
Parameters:
- `DEPTH_LOG2`, default 9, log2 of the RX and TX buffer depth (entries).
- `RX_GAP`, default 2, cycles `rde_n` is held high after a packet's last byte is read (≥1).
- `TX_PKT`, default 512, writes accepted before `txe_n` is forced high (USB packet emulation).
- `TX_GAP`, default 4, cycles `txe_n` is held high after a TX packet closes (≥1).

Ports:
- `ftdi_clk`, in, 1, the only clock.
- `rst`, in, 1. Reset is `rst`, synchronous, active-high. The clock is `ftdi_clk`.
- `src_data`, in, 8, byte to deliver to the host.
- `src_last`, in, 1, marks the last byte of a packet.
- `src_valid`, in, 1, source byte valid.
- `src_ready`, out, 1, RX buffer not full.
- `snk_data`, out, 8, byte written by the host, head of the TX buffer.
- `snk_valid`, out, 1, TX buffer not empty.
- `snk_ready`, in, 1, sink accepts the byte.
- `ftdi_data`, inout, 8, shared data bus.
- `ftdi_rde_n`, out, 1, RX data available, active-low.
- `ftdi_txe_n`, out, 1, TX space available, active-low.
- `ftdi_rd_n`, in, 1, host read strobe.
- `ftdi_oe_n`, in, 1, host output enable (device drives the bus).
- `ftdi_wr_n`, in, 1, host write strobe.
- `ftdi_siwu`, in, 1, send-immediate, active-low.
- `suspend_req`, in, 1, request suspend.
- `ftdi_suspend_n`, out, 1, suspended, active-low.
- `rx_level`, out, DEPTH_LOG2+1, RX occupancy.
- `tx_level`, out, DEPTH_LOG2+1, TX occupancy.
- `siwu_count`, out, 8, count of accepted siwu flushes. Wraps.
- `proto_err`, out, 1, sticky protocol violation.
- `err_count`, out, 8, violation count. Saturates at 255.

## Operation
- RX buffer entries are 9 bits wide (data plus last). It is a first-word-fall-through buffer. It is pushed on `src_valid && src_ready`.
- RX FSM has two states:
  - `RX_AVAIL`: `rde_n` = RX buffer empty.
  - `RX_GAP`: `rde_n` = 1. A counter loads `RX_GAP`. The FSM returns to `RX_AVAIL` when the counter reaches 0.
- RX pop occurs when `!rd_n && !oe_n && !rde_n`. Popping an entry with last=1 transitions to `RX_GAP`.
- `ftdi_data` = RX head data when `!oe_n`, otherwise `8'hZZ`. An empty RX buffer drives `8'h00`.
- TX push occurs when `!wr_n && !txe_n`, capturing `ftdi_data`. TX pop occurs when `snk_valid && snk_ready`. A simultaneous push and pop leaves the level unchanged.
- TX FSM has two states:
  - `TX_OPEN`: `txe_n` = TX buffer full. The packet counter increments on each push.
  - `TX_GAP`: `txe_n` = 1 for `TX_GAP` cycles.
- `TX_OPEN` moves to `TX_GAP` in two cases:
  - The push that makes the packet count equal `TX_PKT`.
  - A falling edge on `siwu`. This clears the packet count and increments `siwu_count`. A push in the same cycle is accepted first.
- Suspend:
  - `ftdi_suspend_n <= ~suspend_req`.
  - While suspended, `rde_n` = `txe_n` = 1, and no push or pop occurs on the FTDI side.
  - Both FSMs hold state.
- `rd_n` or `wr_n` asserted while the matching flag is high has no effect.

## Timing
- Reset values:
  - `rde_n` = `txe_n` = `suspend_n` = 1.
  - `ftdi_data` = Z (if `oe_n` = 1).
  - `snk_valid` = 0, `src_ready` = 1.
  - Levels = 0, counters = 0, `proto_err` = 0.
  - FSMs in `RX_AVAIL` / `TX_OPEN`.
- Flag timing:
  - `rde_n` and `txe_n` decode registered state only, with no combinational path from FTDI inputs.
  - Each flag updates in the cycle after the pop or push that changes it.
- Data latency:
  - `ftdi_data` follows `oe_n` combinationally.
  - The next RX byte appears on the bus the cycle after a pop.
  - A TX byte becomes visible on `snk_*` the cycle after its push.
- Gaps:
  - After the last-byte pop, `rde_n` is high for exactly `RX_GAP` cycles, then low if data remains.
  - `TX_GAP` behaves identically on `txe_n`.
- Reset mid-packet flushes both buffers.

## Configuration
- `FT_DEV_PROTO_CHECK_EN` defined compiles in the protocol checker. Each cycle it sets `proto_err` and increments `err_count` when any of these holds:
  - `!rd_n && rde_n`
  - `!rd_n && oe_n`
  - `!wr_n && txe_n`
  - `!wr_n && !oe_n` (bus contention)
- Multiple violations in one cycle count once.
- Undefined: `proto_err` and `err_count` are tied to 0. The ports remain present.

## Structure
- Package `ft_dev_pkg` contains:
  - RX and TX state enums.
  - An RX entry struct {last, data[7:0]}.
  - Error-code constants.
- Sub-module `ft_dev_sync_fifo` is a single-clock FWFT buffer with level output, parameterised by width and depth. It is instanced twice: 9-bit RX and 8-bit TX.

## Test plan
- Reset behaviour: assert `rst` 3 cycles with `oe_n` = 1 → `rde_n` = `txe_n` = 1, `ftdi_data` = Z, levels 0; `txe_n` = 0 the cycle after release.
- RX packet with gap: inject A1, A2, A3(last), B1(last); host holds `oe_n` low and pulses `rd_n` →
  - Bytes are read as A1, A2, A3.
  - `rde_n` is high for 2 cycles.
  - B1 is then read and `rx_level` returns to 0.
- TX streaming: host writes 10 to 13 with `snk_ready` = 1 → sink receives 10, 11, 12, 13 in order.
- TX full and packet close:
  - With `snk_ready` = 0 and `DEPTH_LOG2` = 4, 16 writes → `txe_n` goes high and a 17th `wr_n` is ignored. One pop → `txe_n` low.
  - With `TX_PKT` = 8, `txe_n` is high 4 cycles after the 8th write.
- siwu flush: pulse `siwu` after 5 writes → `txe_n` high 4 cycles, `siwu_count` = 1, packet count restarts.
- Protocol checker (with `FT_DEV_PROTO_CHECK_EN`): `rd_n` low with `oe_n` high for 1 cycle → `proto_err` = 1, `err_count` = 1, `rx_level` unchanged.
